// File: rtl/rv64g_l2_pkg.sv
// Shared L2 definitions: TileLink B-channel opcodes, probe cap params and
// the probe scheduler state encoding.
package rv64g_l2_pkg;

    localparam logic [2:0] TL_B_PROBE = 3'd6;

    localparam logic [2:0] CAP_TO_T = 3'd0;
    localparam logic [2:0] CAP_TO_B = 3'd1;
    localparam logic [2:0] CAP_TO_N = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_DONE
    } probe_state_e;

endpackage

// File: rtl/rv64g_l2_prio_enc.sv
// Lowest-index-wins priority encoder; picks the next core to probe.
module rv64g_l2_prio_enc #(
    parameter  int CORES = 4,
    localparam int CID_W = $clog2(CORES)
) (
    input  logic [CORES-1:0] req,
    output logic [CID_W-1:0] idx,
    output logic             valid
);

    // Scan high to low so the lowest set bit is the last write.
    always_comb begin
        idx = '0;
        for (int i = CORES - 1; i >= 0; i--) begin
            if (req[i]) idx = CID_W'(i);
        end
    end

    assign valid = |req;

endmodule

// File: rtl/rv64g_l2_probe_sched.sv
// L2 probe round scheduler: issues one B-channel Probe per core in the
// start mask, collects ProbeAcks on C and reports done/dirty/error status.
module rv64g_l2_probe_sched #(
    parameter  int CORES  = 4,
    parameter  int ADDR_W = 64,
    localparam int CID_W  = $clog2(CORES)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [CORES-1:0]  start_mask_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [2:0]        start_param_i,
    output logic [2:0]        b_opcode_o,
    output logic [2:0]        b_param_o,
    output logic [ADDR_W-1:0] b_address_o,
    output logic [CID_W-1:0]  b_dest_o,
    output logic              b_valid_o,
    input  logic              b_ready_i,
    input  logic              ack_valid_i,
    input  logic [CID_W-1:0]  ack_id_i,
    input  logic              ack_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              dirty_o,
    output logic [CORES-1:0]  pending_o,
    output logic              err_o
);

    import rv64g_l2_pkg::*;

    probe_state_e      state_q, state_d;
    logic [CORES-1:0]  unsent_q, unsent_d;
    logic [CORES-1:0]  pending_q, pending_d;
    logic [CORES-1:0]  ack_hit, ack_ok, b_sel;
    logic              dirty_q, dirty_d;
    logic              err_q;
    logic              load;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        param_q;
    logic [CID_W-1:0]  enc_idx;
    logic              enc_valid;
    logic              b_fire;
    logic              ack_accept;

    // Destination is derived from unsent, which only changes on a handshake,
    // so the B payload is inherently stable while a probe waits for ready.
    rv64g_l2_prio_enc #(.CORES(CORES)) u_prio (
        .req   (unsent_q),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    assign b_valid_o = (state_q == ST_ISSUE) && enc_valid;
    assign b_fire    = b_valid_o && b_ready_i;

    always_comb begin
        ack_hit = '0;
        b_sel   = '0;
        for (int i = 0; i < CORES; i++) begin
            ack_hit[i] = ack_valid_i && (ack_id_i == CID_W'(i));
            b_sel[i]   = b_fire && (enc_idx == CID_W'(i));
        end
    end

    // An ack is only legal for a core that was probed and has not yet acked;
    // an ack racing its own probe handshake still sees the unsent bit set.
    assign ack_ok     = ack_hit & pending_q & ~unsent_q;
    assign ack_accept = |ack_ok;

    always_comb begin
        state_d   = state_q;
        unsent_d  = unsent_q & ~b_sel;
        pending_d = pending_q & ~ack_ok;
        dirty_d   = dirty_q | (ack_accept & ack_data_i);
        load      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    load    = 1'b1;
                    dirty_d = 1'b0;
                    if (|start_mask_i) begin
                        unsent_d  = start_mask_i;
                        pending_d = start_mask_i;
                        state_d   = ST_ISSUE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ISSUE: begin
                if (pending_d == '0)     state_d = ST_DONE;
                else if (unsent_d == '0) state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (pending_d == '0) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            unsent_q  <= '0;
            pending_q <= '0;
            dirty_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            unsent_q  <= unsent_d;
            pending_q <= pending_d;
            dirty_q   <= dirty_d;
            err_q     <= ack_valid_i && !ack_accept;
        end
    end

    always_ff @(posedge clk_i) begin
        if (load) begin
            addr_q  <= start_addr_i;
            param_q <= start_param_i;
        end
    end

    assign b_opcode_o  = TL_B_PROBE;
    assign b_param_o   = param_q;
    assign b_address_o = addr_q;
    assign b_dest_o    = enc_idx;
    assign busy_o      = (state_q == ST_ISSUE) || (state_q == ST_WAIT_ACK);
    assign done_o      = (state_q == ST_DONE);
    assign dirty_o     = dirty_q;
    assign pending_o   = pending_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_rv64g_l2_probe_sched.sv
// Directed bench for the probe scheduler; expected B issues, done pulses and
// error pulses are queued by stimulus and consumed by a negedge monitor.
module tb_rv64g_l2_probe_sched;

    localparam int CORES  = 4;
    localparam int ADDR_W = 64;
    localparam int CID_W  = 2;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              start_i;
    logic [CORES-1:0]  start_mask_i;
    logic [ADDR_W-1:0] start_addr_i;
    logic [2:0]        start_param_i;
    logic [2:0]        b_opcode_o;
    logic [2:0]        b_param_o;
    logic [ADDR_W-1:0] b_address_o;
    logic [CID_W-1:0]  b_dest_o;
    logic              b_valid_o;
    logic              b_ready_i;
    logic              ack_valid_i;
    logic [CID_W-1:0]  ack_id_i;
    logic              ack_data_i;
    logic              busy_o, done_o, dirty_o, err_o;
    logic [CORES-1:0]  pending_o;

    rv64g_l2_probe_sched #(.CORES(CORES), .ADDR_W(ADDR_W)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .start_mask_i  (start_mask_i),
        .start_addr_i  (start_addr_i),
        .start_param_i (start_param_i),
        .b_opcode_o    (b_opcode_o),
        .b_param_o     (b_param_o),
        .b_address_o   (b_address_o),
        .b_dest_o      (b_dest_o),
        .b_valid_o     (b_valid_o),
        .b_ready_i     (b_ready_i),
        .ack_valid_i   (ack_valid_i),
        .ack_id_i      (ack_id_i),
        .ack_data_i    (ack_data_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .dirty_o       (dirty_o),
        .pending_o     (pending_o),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [1:0]  dest;
        logic [63:0] addr;
        logic [2:0]  param;
    } b_exp_t;

    typedef struct packed {
        logic chk_dirty;
        logic dirty;
    } done_exp_t;

    b_exp_t     b_q[$];
    done_exp_t  done_q[$];
    logic [3:0] err_q[$];

    b_exp_t     eb;
    done_exp_t  ed;
    logic [3:0] ee;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_round(input logic [3:0] mask, input logic [63:0] addr, input logic [2:0] param);
        start_i       = 1'b1;
        start_mask_i  = mask;
        start_addr_i  = addr;
        start_param_i = param;
        step();
        start_i = 1'b0;
    endtask

    // Monitor: every observed event must match the head of its queue.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1) begin
            if (b_valid_o && b_ready_i) begin
                if (b_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL b_unexpected: probe to dest %0d, none expected", b_dest_o);
                end else begin
                    eb = b_q.pop_front();
                    chk("b_dest", b_dest_o, eb.dest);
                    chk("b_opcode", b_opcode_o, 3'd6);
                    chk("b_param", b_param_o, eb.param);
                    chk("b_address", b_address_o, eb.addr);
                end
            end
            if (done_o) begin
                if (done_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL done_unexpected: done_o=1, none expected");
                end else begin
                    ed = done_q.pop_front();
                    if (ed.chk_dirty) chk("done_dirty", dirty_o, ed.dirty);
                    chk("done_pending", pending_o, 4'b0000);
                end
            end
            if (err_o) begin
                if (err_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL err_unexpected: err_o=1, none expected");
                end else begin
                    ee = err_q.pop_front();
                    chk("err_pending", pending_o, ee);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_ni        = 1'b0;
        start_i       = 1'b0;
        start_mask_i  = '0;
        start_addr_i  = '0;
        start_param_i = '0;
        b_ready_i     = 1'b0;
        ack_valid_i   = 1'b0;
        ack_id_i      = '0;
        ack_data_i    = 1'b0;
        step(); step();
        chk("rst_b_valid", b_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_pending", pending_o, 0);
        chk("rst_dirty", dirty_o, 0);
        rst_ni = 1'b1;
        step();

        // Two probes back to back, acks out of order, clean result.
        b_ready_i = 1'b1;
        b_q.push_back('{dest: 2'd1, addr: 64'h8000_0040, param: 3'd2});
        b_q.push_back('{dest: 2'd3, addr: 64'h8000_0040, param: 3'd2});
        start_round(4'b1010, 64'h8000_0040, 3'd2);
        chk("t1_first", {b_valid_o, b_dest_o}, 3'b101);
        step();
        chk("t1_second", {b_valid_o, b_dest_o}, 3'b111);
        step();
        chk("t1_wait", {busy_o, b_valid_o}, 2'b10);
        chk("t1_pending", pending_o, 4'b1010);
        ack_valid_i = 1'b1; ack_id_i = 2'd3; ack_data_i = 1'b0;
        step();
        chk("t1_pending_ack3", pending_o, 4'b0010);
        chk("t1_not_done", done_o, 0);
        ack_id_i = 2'd1;
        done_q.push_back('{chk_dirty: 1'b1, dirty: 1'b0});
        step();
        ack_valid_i = 1'b0;
        chk("t1_done", done_o, 1);
        chk("t1_dirty", dirty_o, 0);
        step();
        chk("t1_done_clear", {done_o, busy_o}, 2'b00);

        // Backpressure: payload held while ready is low, dirty ack.
        b_ready_i = 1'b0;
        start_round(4'b0001, 64'h1234_5678_9abc_def0, 3'd1);
        for (int i = 0; i < 5; i++) begin
            chk("t2_stable", {b_valid_o, b_dest_o, b_opcode_o, b_param_o}, {1'b1, 2'd0, 3'd6, 3'd1});
            chk("t2_addr", b_address_o, 64'h1234_5678_9abc_def0);
            step();
        end
        b_q.push_back('{dest: 2'd0, addr: 64'h1234_5678_9abc_def0, param: 3'd1});
        b_ready_i = 1'b1;
        step();
        chk("t2_wait", {busy_o, b_valid_o}, 2'b10);
        ack_valid_i = 1'b1; ack_id_i = 2'd0; ack_data_i = 1'b1;
        done_q.push_back('{chk_dirty: 1'b1, dirty: 1'b1});
        step();
        ack_valid_i = 1'b0; ack_data_i = 1'b0;
        chk("t2_done", done_o, 1);
        step();
        chk("t2_dirty_held", {dirty_o, done_o}, 2'b10);

        // Empty mask: done the very next cycle, nothing on B.
        done_q.push_back('{chk_dirty: 1'b0, dirty: 1'b0});
        start_round(4'b0000, 64'h0, 3'd0);
        chk("t3_done", done_o, 1);
        chk("t3_no_b", {b_valid_o, busy_o}, 2'b00);
        step();
        chk("t3_done_clear", {done_o, b_valid_o}, 2'b00);

        // Ack racing its own probe handshake is an error.
        b_q.push_back('{dest: 2'd1, addr: 64'h40, param: 3'd0});
        b_q.push_back('{dest: 2'd2, addr: 64'h40, param: 3'd0});
        start_round(4'b0110, 64'h40, 3'd0);
        chk("t4_first", {b_valid_o, b_dest_o}, 3'b101);
        step();
        chk("t4_second", {b_valid_o, b_dest_o}, 3'b110);
        ack_valid_i = 1'b1; ack_id_i = 2'd2;
        err_q.push_back(4'b0110);
        step();
        ack_valid_i = 1'b0;
        chk("t4_err", err_o, 1);
        chk("t4_pending", pending_o, 4'b0110);
        step();
        chk("t4_err_clear", err_o, 0);
        ack_valid_i = 1'b1; ack_id_i = 2'd2;
        step();
        chk("t4_ack2", {err_o, pending_o}, 5'b0_0010);
        ack_id_i = 2'd1;
        done_q.push_back('{chk_dirty: 1'b1, dirty: 1'b0});
        step();
        ack_valid_i = 1'b0;
        chk("t4_done", done_o, 1);
        step();

        // Ack while idle.
        ack_valid_i = 1'b1; ack_id_i = 2'd0;
        err_q.push_back(4'b0000);
        step();
        ack_valid_i = 1'b0;
        chk("idle_ack_err", {err_o, busy_o}, 2'b10);
        step();
        chk("idle_ack_err_clear", err_o, 0);

        // Reset in the middle of a round.
        b_q.push_back('{dest: 2'd0, addr: 64'hdead_beef_0000_0080, param: 3'd1});
        b_q.push_back('{dest: 2'd1, addr: 64'hdead_beef_0000_0080, param: 3'd1});
        start_round(4'b1111, 64'hdead_beef_0000_0080, 3'd1);
        step();
        step();
        chk("t5_third", {b_valid_o, b_dest_o}, 3'b110);
        chk("t5_pending", pending_o, 4'b1111);
        rst_ni = 1'b0;
        step();
        chk("t5_rst", {b_valid_o, busy_o, done_o}, 3'b000);
        chk("t5_rst_pending", pending_o, 0);
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_no_done", {done_o, b_valid_o}, 2'b00);
        end

        // Start while busy is ignored.
        b_ready_i = 1'b0;
        start_round(4'b1000, 64'h100, 3'd2);
        chk("t6_dest", {b_valid_o, b_dest_o}, 3'b111);
        start_i = 1'b1; start_mask_i = 4'b0001; start_addr_i = 64'h200; start_param_i = 3'd0;
        step();
        start_i = 1'b0;
        chk("t6_dest_held", {b_valid_o, b_dest_o, b_param_o}, 6'b1_11_010);
        chk("t6_addr_held", b_address_o, 64'h100);
        chk("t6_pending", pending_o, 4'b1000);
        b_q.push_back('{dest: 2'd3, addr: 64'h100, param: 3'd2});
        b_ready_i = 1'b1;
        step();
        chk("t6_wait", {busy_o, b_valid_o}, 2'b10);
        start_i = 1'b1;
        ack_valid_i = 1'b1; ack_id_i = 2'd3;
        done_q.push_back('{chk_dirty: 1'b1, dirty: 1'b0});
        step();
        start_i = 1'b0; ack_valid_i = 1'b0;
        chk("t6_done", {done_o, pending_o}, 5'b1_0000);
        step();
        chk("t6_idle", {busy_o, b_valid_o}, 2'b00);
        step();
        chk("t6_idle2", {busy_o, b_valid_o, done_o}, 3'b000);

        step(); step();
        chk("b_q_drained", b_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        chk("err_q_drained", err_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rv64g_l2_probe_sched.md
RV64G_L2_PROBE_SCHED -- requirements
Module: rv64g_l2_probe_sched

Interface
REQ-001 SHALL have parameter CORES, default 4: number of L1 clients; CID_W = $clog2(CORES).
REQ-002 SHALL have parameter ADDR_W, default 64: probe address width.
REQ-003 SHALL have port clk_i, input, 1: single clock, all logic on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port start_i, input, 1: begin a probe round, from the L2 FSM.
REQ-006 SHALL have port start_mask_i, input, CORES: cores to probe.
REQ-007 SHALL have port start_addr_i, input, ADDR_W: line address to probe.
REQ-008 SHALL have port start_param_i, input, 3: cap param (0=toT, 1=toB, 2=toN).
REQ-009 SHALL have ports b_opcode_o (3), b_param_o (3), b_address_o (ADDR_W), b_dest_o (CID_W), b_valid_o (1), all outputs, and b_ready_i (1), input: TileLink B probe issue.
REQ-010 SHALL have ports ack_valid_i (1), ack_id_i (CID_W) and ack_data_i (1), all inputs: ProbeAck observed on C; ack_data_i marks ProbeAckData.
REQ-011 SHALL have ports busy_o (1), done_o (1), dirty_o (1), pending_o (CORES) and err_o (1), all outputs: status to the FSM and MSHR.

Function
REQ-012 SHALL implement states IDLE, ISSUE, WAIT_ACK and DONE.
REQ-013 In IDLE with start_i=1 and nonzero start_mask_i, SHALL latch mask, address and param, set unsent=pending=mask, clear dirty_o, and go to ISSUE next cycle.
REQ-014 In IDLE with start_i=1 and zero mask, SHALL go to DONE; no B traffic.
REQ-015 SHALL ignore start_i outside IDLE.
REQ-016 In ISSUE, SHALL assert b_valid_o with b_dest_o = lowest-index set bit of unsent, b_opcode_o=3'd6 (Probe), b_param_o=latched param and b_address_o=latched address.
REQ-017 Once b_valid_o is asserted, SHALL keep b_valid_o, b_dest_o, b_param_o and b_address_o stable until b_valid_o & b_ready_i.
REQ-018 On b_valid_o & b_ready_i, SHALL clear that core's unsent bit; when the last bit clears, SHALL go to WAIT_ACK next cycle, at most one probe per cycle.
REQ-019 SHALL accept an ack when ack_valid_i=1 and bit ack_id_i is set in pending & ~unsent, in any state; accepting SHALL clear the pending bit and OR ack_data_i into dirty_o.
REQ-020 On an ack not meeting REQ-019 (unprobed, already acked, or in IDLE/DONE), SHALL assert err_o for one cycle and leave state unchanged.
REQ-021 An ack may arrive in the same cycle as another core's B handshake; both updates SHALL take effect.
REQ-022 When pending becomes zero (ack in WAIT_ACK, or last ack coinciding with the last B handshake in ISSUE), SHALL go to DONE next cycle.
REQ-023 In DONE, SHALL assert done_o for exactly one cycle, then return to IDLE; minimum start-to-done latency is 1 cycle (empty mask).
REQ-024 busy_o SHALL be 1 in ISSUE and WAIT_ACK; pending_o SHALL reflect the pending register.
REQ-025 dirty_o SHALL hold its value from DONE until the next accepted start.

Reset
REQ-026 While rst_ni=0 at a clock edge, SHALL go to IDLE and set unsent, pending, dirty_o, b_valid_o, busy_o, done_o and err_o to 0.
REQ-027 Reset mid-round SHALL drop any outstanding probe without completing its handshake and issue no done_o.
REQ-028 Address, param and dest registers need no reset.

Structure
REQ-029 TileLink opcode constants (PROBE=6) and cap-param constants (toT/toB/toN) SHALL live in the shared package rv64g_l2_pkg.
REQ-030 Lowest-set-bit selection SHALL be one sub-module, rv64g_l2_prio_enc (CORES in -> CID_W index + valid).

Verification
REQ-031 The bench SHALL cover: mask 4'b1010, addr 0x8000_0040, param 2, b_ready_i=1 -> probes to dest 1 then 3 on consecutive cycles; acks 3 then 1 -> done_o one cycle after the second ack, dirty_o=0.
REQ-032 The bench SHALL cover: mask 4'b0001 with b_ready_i low 5 cycles -> b_valid_o and all B fields stable for 5 cycles; ack with ack_data_i=1 -> dirty_o=1 after done_o.
REQ-033 The bench SHALL cover: mask 4'b0000 -> done_o exactly 1 cycle after start_i, no b_valid_o.
REQ-034 The bench SHALL cover: mask 4'b0110, ack_id_i=2 in the same cycle as the B handshake to core 2 -> err_o pulse, pending_o stays 4'b0110; a later valid ack from core 2 is accepted.
REQ-035 The bench SHALL cover: mask 4'b1111 with rst_ni=0 after 2 probes -> IDLE, b_valid_o=0 and pending_o=0 next cycle, and no done_o.
REQ-036 The bench SHALL cover: start_i asserted while busy with mask 4'b0001 -> ignored; the current round completes unchanged.
